icache_fill: RTL
================

Name: icache_fill

Overview:
- Direct-mapped, read-only instruction cache that sits between the fetch stage and the slowmem port.
- Acts as the initiator of the slowmem strobe/rnotw/mfc protocol: it issues line-fill reads and waits for mfc.
- Returns hit plus the instruction word combinationally, so the fetch stage can use it the same cycle, as with a direct memory read.
- A data-side snoop input invalidates lines overwritten by stores.

Parameters:
- IDX_BITS, 4, index width; cache holds 2**IDX_BITS one-word lines.
- NOP_WORD, 16'hffff, word returned on a miss (decodes as OPNOP).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- fetch_req  input  1  fetch stage requests the word at fetch_addr this cycle.
- fetch_addr  input  16  word address (PC) to fetch.
- instruction  output  16  cached word on hit, else NOP_WORD (combinational).
- hit  output  1  fetch_req and the line is valid with a matching tag (combinational).
- busy  output  1  a fill is in progress (state is not IDLE).
- strobe  output  1  slowmem request strobe (registered).
- rnotw  output  1  slowmem read/not-write (registered; always 1 when strobe is 1).
- addr  output  16  slowmem address (registered).
- wdata  output  16  slowmem write data; constant 0.
- mfc  input  1  slowmem memory-fetch-complete.
- rdata  input  16  slowmem read data, valid when mfc=1.
- inv_valid  input  1  a data store is occurring this cycle.
- inv_addr  input  16  address of that store.

Behaviour:
- Address split: index = addr[IDX_BITS-1:0], tag = addr[15:IDX_BITS].
- Arrays: data[ ], tag[ ], valid[ ]. Only valid[ ] is reset.
- Async reset:
  - valid all 0, state IDLE.
  - strobe=0, rnotw=1, addr=0, busy=0, pending-stale flag=0.
  - Reset mid-fill drops the fill. Any later mfc is ignored while in IDLE.
- Lookup is combinational:
  - hit = fetch_req & valid[idx] & (tag[idx]==tag(fetch_addr)).
  - instruction = hit ? data[idx] : NOP_WORD.
- FSM states IDLE, ISSUE, WAIT, FILL.
- IDLE:
  - If fetch_req & !hit: latch fill_addr=fetch_addr, clear stale, go to ISSUE.
  - At that edge, register strobe=1, rnotw=1, addr=fetch_addr.
- ISSUE:
  - Strobe is high for exactly this one cycle.
  - Next edge: strobe=0, go to WAIT.
- WAIT:
  - strobe stays 0.
  - On mfc=1, capture rdata into a fill buffer and go to FILL.
  - No timeout.
- FILL:
  - If !stale: data[idx]=buffer, tag[idx]=tag(fill_addr), valid[idx]=1.
  - Go to IDLE. A new miss can be accepted on the following cycle.
- Miss penalty with MEMDELAY=4:
  - Miss presented in cycle 0; strobe high in cycle 1.
  - slowmem samples the strobe at the end of cycle 1; mfc high in cycle 5.
  - FILL state in cycle 6; the line is written at the end of cycle 6.
  - hit=1 in cycle 7.
- fetch_addr may change during a fill. The fill completes for the latched fill_addr; hit always reflects the current fetch_addr, including hits on other lines during the fill.
- Invalidation:
  - inv_valid clears valid[idx(inv_addr)] when the tags match.
  - If inv_addr==fill_addr while in ISSUE/WAIT/FILL, set stale so the fill does not validate.
  - slowmem already forwards a same-address write to the pending read; the stale rule still applies.
- Simultaneous invalidate and FILL write to the same index: the invalidate wins.
- Only one outstanding request ever exists; the cache never drives a write strobe.

Optional Feature:
- ICACHE_STATS_EN defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0]; both reset to 0 and saturate at 16'hffff.
  - hit_count increments in each cycle with fetch_req & hit.
  - miss_count increments on each IDLE->ISSUE transition. Repeated miss cycles during a fill are not counted.
- Undefined: the ports are absent and there is no counter logic.

Test Plan:
- Reset, fetch_req=1, fetch_addr=16'h0000, mem[0]=16'h1005 -> hit=0 and instruction=16'hffff in cycles 0-6; strobe=1 only in cycle 1 with addr=0; hit=1 and instruction=16'h1005 in cycle 7.
- After that fill, fetch 16'h0010 (same index, different tag), mem[16'h10]=16'h2abc -> miss, fill in 7 cycles; 16'h0000 then misses again (line evicted).
- During the fill of 16'h0001, fetch the already-cached 16'h0000 -> hit=1 immediately, busy=1, and the fill of 16'h0001 still completes.
- Store snoop inv_addr=16'h0001 in WAIT -> after mfc the line is not validated; the next fetch of 16'h0001 misses again.
- Assert reset during WAIT -> strobe=0, busy=0, valid cleared; the late mfc is ignored; fetch of 16'h0000 misses.
- ICACHE_STATS_EN: 1 miss then 5 hit cycles -> miss_count=1, hit_count=5; preload hit_count=16'hfffe and apply 3 hits -> 16'hffff.

Source files
------------

// File: rtl/icache_fill.sv
// icache_fill: direct-mapped, read-only instruction cache between the fetch
// stage and the slowmem port, with line fill and data-side store snooping.
//
// Ports:
//   clk, reset              rising-edge clock, async active-high reset
//   fetch_req, fetch_addr   fetch lookup request and word address (PC)
//   instruction, hit        combinational lookup result (NOP_WORD on miss)
//   busy                    a line fill is in progress
//   strobe, rnotw, addr     registered slowmem request (read only)
//   wdata                   slowmem write data, tied to zero
//   mfc, rdata              slowmem completion and read data
//   inv_valid, inv_addr     data-side store snoop
//   hit_count, miss_count   saturating counters, only with ICACHE_STATS_EN
//
// Optional feature macro: ICACHE_STATS_EN (adds the two counter outputs).

module icache_fill #(
    parameter int          IDX_BITS = 4,
    parameter logic [15:0] NOP_WORD = 16'hffff
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    output logic [15:0] instruction,
    output logic        hit,
    output logic        busy,
    output logic        strobe,
    output logic        rnotw,
    output logic [15:0] addr,
    output logic [15:0] wdata,
    input  logic        mfc,
    input  logic [15:0] rdata,
    input  logic        inv_valid,
    input  logic [15:0] inv_addr
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    localparam int LINES    = 1 << IDX_BITS;
    localparam int TAG_BITS = 16 - IDX_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FILL
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [15:0]         data_mem [LINES];
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [LINES-1:0]    valid;

    logic [15:0] fill_addr;
    logic [15:0] fill_buf;
    logic        stale;

    logic [IDX_BITS-1:0] f_idx;
    logic [TAG_BITS-1:0] f_tag;
    logic [IDX_BITS-1:0] i_idx;
    logic [TAG_BITS-1:0] i_tag;
    logic [IDX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0] w_tag;

    logic inv_hit;
    logic inv_fill;
    logic start_fill;
    logic fill_we;

    assign f_idx = fetch_addr[IDX_BITS-1:0];
    assign f_tag = fetch_addr[15:IDX_BITS];
    assign i_idx = inv_addr[IDX_BITS-1:0];
    assign i_tag = inv_addr[15:IDX_BITS];
    assign w_idx = fill_addr[IDX_BITS-1:0];
    assign w_tag = fill_addr[15:IDX_BITS];

    assign wdata = '0;

    // Combinational lookup so fetch can consume the word in the same cycle.
    always_comb begin
        hit         = fetch_req & valid[f_idx] & (tag_mem[f_idx] == f_tag);
        instruction = hit ? data_mem[f_idx] : NOP_WORD;
    end

    always_comb begin
        inv_hit = inv_valid & valid[i_idx] & (tag_mem[i_idx] == i_tag);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (fetch_req && !hit) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mfc) begin
                    state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy       = (state != S_IDLE);
        start_fill = (state == S_IDLE) & fetch_req & ~hit;
        // A store to the line being filled this very cycle must also
        // block validation, not only one seen on an earlier cycle.
        inv_fill   = busy & inv_valid & (inv_addr == fill_addr);
        fill_we    = (state == S_FILL) & ~stale & ~inv_fill;
    end

    // Registered slowmem request and fill bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe    <= 1'b0;
            rnotw     <= 1'b1;
            addr      <= '0;
            fill_addr <= '0;
            stale     <= 1'b0;
        end else begin
            rnotw <= 1'b1;
            if (start_fill) begin
                strobe    <= 1'b1;
                addr      <= fetch_addr;
                fill_addr <= fetch_addr;
                stale     <= 1'b0;
            end else begin
                if (state == S_ISSUE) begin
                    strobe <= 1'b0;
                end
                if (inv_fill) begin
                    stale <= 1'b1;
                end
            end
        end
    end

    // Valid bits. The invalidate is applied last so it wins over a fill
    // write landing on the same index in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
        end else begin
            if (fill_we) begin
                valid[w_idx] <= 1'b1;
            end
            if (inv_hit) begin
                valid[i_idx] <= 1'b0;
            end
        end
    end

    // Data and tag storage is meaningless until valid, so it is not reset.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[w_idx] <= fill_buf;
            tag_mem[w_idx]  <= w_tag;
        end
    end

    always_ff @(posedge clk) begin
        if ((state == S_WAIT) && mfc) begin
            fill_buf <= rdata;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && (hit_count != 16'hffff)) begin
                hit_count <= hit_count + 16'd1;
            end
            if (start_fill && (miss_count != 16'hffff)) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule
